// File: rtl/sram_mem_stage.sv
// sram_mem_stage: memory-stage controller placed after the EXE/MEM register.
// Each 32-bit load or store is split into two 16-bit SRAM accesses (low half
// first), and each half is held for WAIT_CYCLES+1 cycles. While an access is in
// flight, ready is held low to freeze the upstream pipeline.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   mem_read_in  load request
//   mem_write_in store request (wins if both are set)
//   ALU_res_in   byte address
//   val_Rm_in    store data
//   ready        high = pipeline may advance
//   rd_data      load result, valid in the cycle where ready rises after a load
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_in   SRAM read data (combinational from sram_addr)
//   sram_dq_oe   high = drive the data bus
//   sram_we_n    active-low write enable
module sram_mem_stage #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] val_Rm_in,
  output logic        ready,
  output logic [31:0] rd_data,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccLo = 2'd1;
  localparam logic [1:0] StAccHi = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // A one-bit counter is kept even with no wait states so the width is never zero.
  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [16:0]     idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            is_wr_q, is_wr_d;
  logic [31:0]     rd_data_q, rd_data_d;

  logic        req;
  logic        cnt_done;
  logic [31:0] byte_off;
  logic        unused_off_bits;

  assign req      = mem_read_in | mem_write_in;
  assign cnt_done = (cnt_q == CntMax);
  // Subtraction wraps modulo 2^32; only bits [18:2] form the word index.
  assign byte_off = ALU_res_in - BASE_ADDR;
  assign unused_off_bits = ^{byte_off[31:19], byte_off[1:0]};

  assign rd_data = rd_data_q;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StAccLo;
          cnt_d   = '0;
          idx_d   = byte_off[18:2];
          wdata_d = val_Rm_in;
          is_wr_d = mem_write_in;
        end
      end
      StAccLo: begin
        if (cnt_done) begin
          state_d = StAccHi;
          cnt_d   = '0;
          if (!is_wr_q) begin
            rd_data_d[15:0] = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StAccHi: begin
        if (cnt_done) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!is_wr_q) begin
            rd_data_d[31:16] = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. Reset gates the bus combinationally so an aborted store stops
  // writing in the very cycle reset is asserted.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (!rst) begin
      ready = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          ready = ~req;
        end
        StAccLo: begin
          sram_addr = {idx_q, 1'b0};
          if (is_wr_q) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = wdata_q[15:0];
          end
        end
        StAccHi: begin
          sram_addr = {idx_q, 1'b1};
          if (is_wr_q) begin
            sram_we_n   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = wdata_q[31:16];
          end
        end
        default: begin
          ready = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule
